bcd_digit_parser: RTL and testbench
===================================

BCD_DIGIT_PARSER -- requirements
Module: bcd_digit_parser

Interface
REQ-001 Parameter: DIGITS, 6, number of BCD digits per conversion.
REQ-002 Parameter: VALUE_W, 20, binary result width; SHALL satisfy 2^VALUE_W > 10^DIGITS - 1.
REQ-003 Port: clock_50Mhz  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  a digit set is offered.
REQ-006 Port: in_ready  output  1  block accepts a digit set this cycle.
REQ-007 Port: in_digits  input  DIGITS x 4  BCD digits; index 0 = units, index DIGITS-1 = most significant.
REQ-008 Port: out_valid  output  1  result is held and available.
REQ-009 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-010 Port: out_value  output  VALUE_W  unsigned binary value of the accepted digits.
REQ-011 Port: out_error  output  1  at least one accepted digit was > 9.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CONVERT, DONE.
REQ-013 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only; both are functions of the registered state.
REQ-014 An input handshake (in_valid & in_ready at an edge) SHALL capture in_digits into an internal register, clear the accumulator and the error flag, load the digit index to DIGITS-1, and enter CONVERT.
REQ-015 In CONVERT, each cycle SHALL compute acc <= acc*10 + d, where d is the captured digit at the current index, then decrement the index; the multiply SHALL be implemented as (acc<<3)+(acc<<1), with no divider or modulo.
REQ-016 A captured digit > 9 SHALL contribute d = 0 and set the error flag; the flag stays set until the next input handshake.
REQ-017 After the step at index 0, the FSM SHALL enter DONE; total latency from the input-handshake edge to the first cycle with out_valid = 1 is DIGITS+1 edges.
REQ-018 In DONE, out_value and out_error SHALL hold stable until out_ready = 1; that edge SHALL return the FSM to IDLE.
REQ-019 Changes to in_digits or in_valid after capture SHALL NOT affect the conversion in progress.
REQ-020 in_valid asserted outside IDLE SHALL be ignored with no capture; in_valid = 1 in IDLE with out_ready irrelevant SHALL be captured.
REQ-021 Back-to-back throughput SHALL be one conversion per DIGITS+2 cycles minimum (one IDLE cycle between results).
REQ-022 Accumulator arithmetic SHALL use VALUE_W+4 bits internally; out_value SHALL be the low VALUE_W bits, which are exact for all legal inputs per REQ-002.
REQ-023 out_value and out_error SHALL be driven from registers, never combinationally from in_digits.

Reset
REQ-024 reset_n = 0 SHALL immediately force state IDLE, in_ready = 1, out_valid = 0, out_value = 0, out_error = 0, and clear the accumulator, index, and captured digits.
REQ-025 Reset asserted during CONVERT or DONE SHALL abandon the conversion; no out_valid pulse SHALL follow the reset release.
REQ-026 On the first edge after reset_n deasserts, the block SHALL accept an input handshake.

Verification
REQ-027 Digits (MSD..LSD) 1,2,3,4,5,6 with out_ready = 1 -> out_valid high exactly 7 edges after capture, out_value = 0x1E240, out_error = 0.
REQ-028 Digits 9,9,9,9,9,9 -> out_value = 0xF423F, out_error = 0; digits all 0 -> out_value = 0x00000, out_error = 0.
REQ-029 Digits 1,1,1,0xA,1,1 -> out_value = 0x1B1A3 (111011), out_error = 1; next legal conversion -> out_error = 0.
REQ-030 out_ready held 0 for 10 cycles in DONE while in_valid = 1 and in_digits toggles -> out_value stable, in_ready = 0, no capture; the out_ready pulse returns to IDLE, then the next set is captured.
REQ-031 reset_n pulsed low at the third CONVERT cycle -> all outputs take reset values asynchronously, no out_valid follows, and a subsequent conversion of 0,0,0,0,4,2 yields 0x0002A.
REQ-032 Random legal digit sets with random in_valid/out_ready gaps -> every out_value equals the decimal interpretation, with one result per accepted input, in order.

Source files
------------

// File: rtl/bcd_digit_parser_if.sv
// Handshake bundle for the BCD digit parser: digit-set input channel and binary result channel.
// Digit index 0 is the units digit; DIGITS-1 is the most significant.
interface bcd_digit_parser_if #(
  parameter int DIGITS  = 6,
  parameter int VALUE_W = 20
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DIGITS-1:0][3:0] in_digits;
  logic                   out_valid;
  logic                   out_ready;
  logic [VALUE_W-1:0]     out_value;
  logic                   out_error;

  modport master (
    output in_valid, in_digits, out_ready,
    input  in_ready, out_valid, out_value, out_error
  );

  modport slave (
    input  in_valid, in_digits, out_ready,
    output in_ready, out_valid, out_value, out_error
  );
endinterface

// File: rtl/bcd_digit_parser.sv
// Converts a captured set of BCD digits to unsigned binary, one digit per clock, MSD first.
// Digits above 9 count as zero and raise a sticky error flag for that conversion.
module bcd_digit_parser #(
  parameter int DIGITS  = 6,
  parameter int VALUE_W = 20
) (
  input logic               clock_50Mhz,
  input logic               reset_n,
  bcd_digit_parser_if.slave bus
);
  localparam int ACC_W = VALUE_W + 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [DIGITS-1:0][3:0] r_digits;
  logic [ACC_W-1:0]       r_acc;
  logic                   r_err;
  logic [IDX_W-1:0]       r_idx;

  logic [3:0]             w_digit;
  logic                   w_digit_bad;
  logic [3:0]             w_digit_eff;
  logic [ACC_W-1:0]       w_acc_next;
  logic                   w_capture;

  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_digit = r_digits[i];
      end
    end
  end

  assign w_digit_bad = (w_digit > 4'd9);
  assign w_digit_eff = w_digit_bad ? 4'd0 : w_digit;
  // acc*10 built from two shifts so no multiplier is inferred
  assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_digit_eff);
  assign w_capture   = bus.in_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.in_valid)      w_state_next = S_CONVERT;
      S_CONVERT: if (r_idx == '0)       w_state_next = S_DONE;
      S_DONE:    if (bus.out_ready)     w_state_next = S_IDLE;
      default:                          w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_digits <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
      r_idx    <= '0;
    end else if (w_capture) begin
      r_digits <= bus.in_digits;
      r_acc    <= '0;
      r_err    <= 1'b0;
      r_idx    <= IDX_TOP;
    end else if (r_state == S_CONVERT) begin
      r_acc <= w_acc_next;
      r_err <= r_err | w_digit_bad;
      if (r_idx != '0) begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.out_value = r_acc[VALUE_W-1:0];
  assign bus.out_error = r_err;
endmodule

// File: tb/tb_bcd_digit_parser.sv
// Directed bench for bcd_digit_parser: known vectors, hold/backpressure, mid-conversion reset, random sets.
module tb_bcd_digit_parser;
  localparam int DIGITS  = 6;
  localparam int VALUE_W = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  bcd_digit_parser_if #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) bus ();

  bcd_digit_parser #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) dut (
    .clock_50Mhz (clk),
    .reset_n     (rst_n),
    .bus         (bus)
  );

  always #10 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count negedges from the first post-capture cycle until out_valid rises (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Called at a negedge in IDLE; in_valid stays high with scrambled digits during CONVERT.
  task automatic convert(input logic [23:0] digs, input logic [19:0] expv,
                         input logic experr, input string tag);
    int lat;
    check({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_digits = digs;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_digits = ~digs;
    check({tag, ":in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    wait_done(lat);
    bus.in_valid = 1'b0;
    check({tag, ":latency"}, 32'(lat), 32'(DIGITS));
    check({tag, ":value"}, 32'(bus.out_value), 32'(expv));
    check({tag, ":error"}, 32'(bus.out_error), 32'(experr));
    @(negedge clk);
    check({tag, ":back_idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    int          lat;
    int          v;
    int          p;
    int          n_ov;
    logic [23:0] dg;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_digits = '0;

    #1;
    check("rst:in_ready", 32'(bus.in_ready), 32'd1);
    check("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("rst:out_value", 32'(bus.out_value), 32'd0);
    check("rst:out_error", 32'(bus.out_error), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset release must capture
    convert(24'h123456, 20'h1E240, 1'b0, "v123456");
    convert(24'h999999, 20'hF423F, 1'b0, "v999999");
    convert(24'h000000, 20'h00000, 1'b0, "v000000");
    convert(24'h111A11, 20'h1B1A3, 1'b1, "v111A11");
    convert(24'h654321, 20'h9FBF1, 1'b0, "v654321");
    convert(24'hFFFFFF, 20'h00000, 1'b1, "vFFFFFF");
    convert(24'h90000F, 20'hDBBA0, 1'b1, "v90000F");

    // backpressure: result must hold while in_valid is offered and ignored
    bus.in_digits = 24'h123456;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(lat);
    check("hold:latency", 32'(lat), 32'(DIGITS));
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_digits = (c % 2 == 1) ? 24'h999999 : 24'h000000;
      @(negedge clk);
      check("hold:value", 32'(bus.out_value), 32'h1E240);
      check("hold:flags", {29'd0, bus.in_ready, bus.out_valid, bus.out_error}, 32'b010);
    end
    bus.in_digits = 24'h000777;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold:released", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("hold:next_captured", 32'(bus.in_ready), 32'd0);
    wait_done(lat);
    check("hold:next_latency", 32'(lat), 32'(DIGITS));
    check("hold:next_value", 32'(bus.out_value), 32'h00309);
    @(negedge clk);

    // reset in the third CONVERT cycle abandons the conversion
    bus.in_digits = 24'h999999;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst:in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst:out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst:out_value", 32'(bus.out_value), 32'd0);
    check("mid_rst:out_error", 32'(bus.out_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_ov = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) n_ov++;
    end
    check("mid_rst:no_out_valid", 32'(n_ov), 32'd0);
    convert(24'h000042, 20'h0002A, 1'b0, "v000042");

    // random legal sets with random gaps; expected value is the decimal reading of the digits
    for (int t = 0; t < 8; t++) begin
      v = 0;
      p = 1;
      for (int k = 0; k < DIGITS; k++) begin
        dg[k*4 +: 4] = 4'($urandom_range(0, 9));
        v += int'(dg[k*4 +: 4]) * p;
        p *= 10;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.in_digits = dg;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("rand:accepted", 32'(bus.in_ready), 32'd0);
      wait_done(lat);
      check("rand:latency", 32'(lat), 32'(DIGITS));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      check("rand:value", 32'(bus.out_value), 32'(v));
      check("rand:error", 32'(bus.out_error), 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("rand:released", 32'(bus.out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
